// File: rtl/ifft_pkg.sv
// Shared definitions for the 16-point radix-2 IFFT address controller:
// sizes, FSM encoding and the load-order bit reversal.
package ifft_pkg;

   localparam int N_POINTS = 16;
   localparam int ADDR_W   = 4;
   localparam int N_STAGES = 4;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_CALC   = 3'd2,
      S_DRAIN  = 3'd3,
      S_UNLOAD = 3'd4
   } state_e;

   function automatic logic [ADDR_W-1:0] bitrev4(input logic [ADDR_W-1:0] a);
      return {a[0], a[1], a[2], a[3]};
   endfunction

endpackage

// File: rtl/ifft_bf_addr_gen.sv
// Butterfly leg addresses and twiddle index for one (stage, k) pair.
// Purely combinational; all arithmetic stays within 4 bits.
module ifft_bf_addr_gen
   import ifft_pkg::*;
(
   input  logic [1:0]        stage,
   input  logic [2:0]        k,
   output logic [ADDR_W-1:0] bf_addr_a,
   output logic [ADDR_W-1:0] bf_addr_b,
   output logic [2:0]        tw_idx
);

   logic [ADDR_W-1:0] k4;
   logic [ADDR_W-1:0] span;
   logic [ADDR_W-1:0] lo;
   logic [ADDR_W-1:0] tw4;
   logic [2:0]        up_sh;

   always_comb begin
      k4        = {1'b0, k};
      span      = 4'd1 << stage;
      lo        = k4 & (span - 4'd1);
      // 3-bit shift amount so stage 3 shifts by 4 rather than wrapping to 0
      up_sh     = {1'b0, stage} + 3'd1;
      bf_addr_a = ((k4 >> stage) << up_sh) | lo;
      bf_addr_b = bf_addr_a + span;
      tw4       = lo << (2'd3 - stage);
      tw_idx    = tw4[2:0];
   end

endmodule

// File: rtl/ifft_addr_ctrl.sv
// Address/control sequencer for an in-place 16-point IFFT:
// bit-reversed load, four butterfly stages with drain gaps, natural-order unload.
module ifft_addr_ctrl
   import ifft_pkg::*;
#(
   parameter int BF_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [ADDR_W-1:0] io_addr,
   output logic [ADDR_W-1:0] bf_addr_a,
   output logic [ADDR_W-1:0] bf_addr_b,
   output logic              mux_sel,
   output logic              mem_we,
   output logic              bf_en,
   output logic [2:0]        tw_idx,
   output logic [1:0]        stage,
   output logic              busy,
   output logic              frame_done
);

   localparam logic [ADDR_W-1:0] LAST_IDX   = 4'(N_POINTS - 1);
   localparam logic [1:0]        LAST_STAGE = 2'(N_STAGES - 1);
   localparam logic [2:0]        DRAIN_LAST = 3'(BF_LAT - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [2:0]        k_q, k_d;
   logic [1:0]        stage_q, stage_d;
   logic [2:0]        drain_q, drain_d;
   logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
   logic              mem_we_q, mem_we_d;
   logic              done_q, done_d;

   logic [ADDR_W-1:0] gen_a, gen_b;
   logic [2:0]        gen_tw;

   ifft_bf_addr_gen u_gen (
      .stage     (stage_q),
      .k         (k_q),
      .bf_addr_a (gen_a),
      .bf_addr_b (gen_b),
      .tw_idx    (gen_tw)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      k_d       = k_q;
      stage_d   = stage_q;
      drain_d   = drain_q;
      ld_addr_d = ld_addr_q;
      mem_we_d  = 1'b0;
      done_d    = 1'b0;
      unique case (state_q)
         S_IDLE, S_LOAD: begin
            if (in_valid) begin
               mem_we_d  = 1'b1;
               ld_addr_d = bitrev4(cnt_q);
               cnt_d     = cnt_q + 4'd1;
               state_d   = S_LOAD;
               if (cnt_q == LAST_IDX) begin
                  state_d = S_CALC;
                  stage_d = 2'd0;
                  k_d     = 3'd0;
               end
            end
         end
         S_CALC: begin
            k_d = k_q + 3'd1;
            if (k_q == 3'd7) begin
               state_d = S_DRAIN;
               drain_d = 3'd0;
            end
         end
         S_DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               drain_d = 3'd0;
               stage_d = stage_q + 2'd1;
               state_d = S_CALC;
               if (stage_q == LAST_STAGE) begin
                  state_d = S_UNLOAD;
                  cnt_d   = 4'd0;
               end
            end else begin
               drain_d = drain_q + 3'd1;
            end
         end
         S_UNLOAD: begin
            if (out_ready) begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == LAST_IDX) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         k_q       <= '0;
         stage_q   <= '0;
         drain_q   <= '0;
         ld_addr_q <= '0;
         mem_we_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         k_q       <= k_d;
         stage_q   <= stage_d;
         drain_q   <= drain_d;
         ld_addr_q <= ld_addr_d;
         mem_we_q  <= mem_we_d;
         done_q    <= done_d;
      end
   end

   assign in_ready   = (state_q == S_IDLE) || (state_q == S_LOAD);
   assign out_valid  = (state_q == S_UNLOAD);
   assign bf_en      = (state_q == S_CALC);
   assign mux_sel    = (state_q == S_CALC) || (state_q == S_DRAIN);
   assign busy       = (state_q != S_IDLE);
   assign mem_we     = mem_we_q;
   assign frame_done = done_q;
   assign stage      = stage_q;
   assign io_addr    = out_valid ? cnt_q : ld_addr_q;
   // Leg addresses are forced to zero whenever no butterfly is issued
   assign bf_addr_a  = bf_en ? gen_a : '0;
   assign bf_addr_b  = bf_en ? gen_b : '0;
   assign tw_idx     = bf_en ? gen_tw : '0;

endmodule

// File: doc/ifft_addr_ctrl.md
IFFT_ADDR_CTRL -- requirements
Module: ifft_addr_ctrl

Interface
REQ-001 The block SHALL have parameter BF_LAT, default 2, giving the butterfly datapath latency in cycles from address issue to write-back (legal range 1..4).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an input sample is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-006 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts an output sample.
REQ-007 The block SHALL have port out_valid, output, 1 bit: the output sample at io_addr is valid.
REQ-008 The block SHALL have port io_addr, output, 4 bits: load/unload address, driving the address-mux input 0.
REQ-009 The block SHALL have port bf_addr_a, output, 4 bits: butterfly upper-leg address, driving the address-mux input 1.
REQ-010 The block SHALL have port bf_addr_b, output, 4 bits: butterfly lower-leg address.
REQ-011 The block SHALL have port mux_sel, output, 1 bit: address-mux select, 0 = io_addr, 1 = bf_addr_a.
REQ-012 The block SHALL have port mem_we, output, 1 bit: sample-memory write enable for load.
REQ-013 The block SHALL have port bf_en, output, 1 bit: a butterfly is issued this cycle.
REQ-014 The block SHALL have port tw_idx, output, 3 bits: twiddle ROM index.
REQ-015 The block SHALL have port stage, output, 2 bits: the current butterfly stage, 0..3.
REQ-016 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-017 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse after the last output sample is accepted.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, CALC, DRAIN and UNLOAD, with the transitions given in REQ-019 to REQ-025.
REQ-019 In IDLE, in_ready SHALL be 1, and an accepted sample SHALL write sample 0 and move the FSM to LOAD with cnt=1.
REQ-020 In LOAD, in_ready SHALL be 1, and each in_valid&&in_ready cycle SHALL assert mem_we, set io_addr=bitrev4(cnt) and increment cnt.
REQ-021 In LOAD, when sample 15 is accepted, the FSM SHALL go to CALC with stage=0 and k=0; when in_valid is low, the FSM SHALL hold with no write.
REQ-022 In CALC, the block SHALL set bf_en=1 and mux_sel=1 for one butterfly per cycle, k=0..7.
REQ-023 The butterfly addresses SHALL be span=2^stage, bf_addr_a=((k>>stage)<<(stage+1))|(k&(span-1)), bf_addr_b=bf_addr_a+span, and tw_idx=(k&(span-1))<<(3-stage), all computed within 4 bits.
REQ-024 After k=7, the FSM SHALL enter DRAIN for exactly BF_LAT cycles with bf_en=0 to avoid read-before-write, then go to CALC with stage+1, or to UNLOAD with cnt=0 after stage 3.
REQ-025 In UNLOAD, the block SHALL set io_addr=cnt (natural order), out_valid=1 and mux_sel=0; cnt SHALL advance only when out_ready=1, and after index 15 is accepted the FSM SHALL return to IDLE and pulse frame_done.
REQ-026 In UNLOAD, when out_ready=0, io_addr and out_valid SHALL hold unchanged (no sample skipped).
REQ-027 Outside LOAD and IDLE, in_ready SHALL be 0 and in_valid SHALL be ignored; no frame overlap is allowed.
REQ-028 mux_sel SHALL be 1 only in CALC and DRAIN, and 0 otherwise.
REQ-029 The frame latency SHALL be 4*(8+BF_LAT) cycles from the last accepted input to the first out_valid.
REQ-030 All outputs SHALL be registered or decoded from registered state only, with no combinational path from in_valid or out_ready to any output except in_ready.
REQ-031 The counters SHALL wrap 15->0 (cnt) and 7->0 (k) only under FSM control, and never free-run.

Reset
REQ-032 When rst=1 at a clock edge, the FSM SHALL go to IDLE with cnt=0, k=0, stage=0 and the drain counter=0, in any state, including mid-frame; the partial frame SHALL be discarded.
REQ-033 During and after reset, the outputs SHALL be in_ready=1, out_valid=0, mem_we=0, bf_en=0, mux_sel=0, io_addr=0, bf_addr_a=0, bf_addr_b=0, tw_idx=0, stage=0, busy=0 and frame_done=0.

Structure
REQ-034 A shared package ifft_pkg SHALL hold the FSM state encoding, N_POINTS=16, ADDR_W=4, N_STAGES=4 and the bitrev4 function.
REQ-035 The butterfly address/twiddle generator (REQ-023) SHALL be a combinational sub-module ifft_bf_addr_gen, with inputs stage and k and outputs bf_addr_a, bf_addr_b and tw_idx.
REQ-036 ifft_addr_ctrl SHALL drive the existing two-input 4-bit address mux through mux_sel and SHALL NOT instantiate it.

Verification
REQ-037 Load: 16 back-to-back in_valid cycles -> io_addr sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with mem_we=1, then CALC.
REQ-038 Stage addressing: stage 2, k=5 -> bf_addr_a=9, bf_addr_b=13, tw_idx=2; stage 3, k=7 -> bf_addr_a=7, bf_addr_b=15, tw_idx=7.
REQ-039 Timing with BF_LAT=2: last input accepted at cycle T -> first out_valid at T+41 (4*(8+2) CALC/DRAIN cycles plus 1).
REQ-040 Backpressure: out_ready toggles 1,0,0,1 during UNLOAD -> io_addr holds for 2 cycles, all 16 addresses 0..15 appear once, frame_done is a single pulse.
REQ-041 Input gaps: in_valid low for 3 cycles mid-LOAD -> no mem_we, cnt holds, the remaining addresses continue the bit-reversed sequence.
REQ-042 Reset mid-CALC (stage 1, k=4) -> next cycle IDLE, all outputs at reset values, and a fresh 16-sample frame completes normally.
